limbus_sysid_checker: RTL and testbench

- Avalon-MM read master that reads the limbus system-ID slave and checks it.
- Reads word 0 (system ID), then word 1 (build timestamp), and compares both against expected values.
- Reports done, pass or fail, and a timeout status.
- Sits beside the Nios/limbus interconnect as a boot-time sanity checker; firmware and bring-up LEDs consume its status.

---
 rtl/limbus_sysid_checker.sv | 188 ++++++++++++++++++
 tb/tb_limbus_sysid_checker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/limbus_sysid_checker.sv
// Boot-time Avalon-MM checker: reads sysid words 0 and 1, compares, reports pass/fail/timeout.
// Optional irq/irq_clr ports when LIMBUS_SYSID_CHK_IRQ_EN is defined.
module limbus_sysid_checker #(
    parameter logic [31:0] EXP_ID         = 32'd1,
    parameter logic [31:0] EXP_TIMESTAMP  = 32'd1384067151,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
`ifdef LIMBUS_SYSID_CHK_IRQ_EN
    output logic        irq,
    input  logic        irq_clr,
`endif
    output logic [31:0] id_rd,
    output logic [31:0] ts_rd
);

    localparam int unsigned RET_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_ID = 3'd1;
    localparam logic [2:0] S_RD_TS = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_RETRY = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [RET_W-1:0] r_retry, w_retry_nxt, w_retry_inc;
    logic             r_autorun, w_autorun_nxt;
    logic             r_pass, w_pass_nxt;
    logic             r_fail, w_fail_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [31:0]      r_id, w_id_nxt;
    logic [31:0]      r_ts, w_ts_nxt;
    logic             r_read, w_read_nxt;
    logic             r_addr, w_addr_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_at_limit;

    assign w_retry_inc = r_retry + RET_W'(1);
    assign w_at_limit  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic; bus outputs are decoded from the next state so they register cleanly.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retry_nxt   = r_retry;
        w_autorun_nxt = r_autorun;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_timeout_nxt = r_timeout;
        w_id_nxt      = r_id;
        w_ts_nxt      = r_ts;
        case (r_state)
            S_IDLE: begin
                if (r_autorun || start) begin
                    w_state_nxt   = S_RD_ID;
                    w_autorun_nxt = 1'b0;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (!avm_waitrequest) begin
                    if (r_state == S_RD_ID) begin
                        w_id_nxt    = avm_readdata;
                        w_state_nxt = S_RD_TS;
                    end else begin
                        w_ts_nxt    = avm_readdata;
                        w_state_nxt = S_CHECK;
                    end
                    w_cnt_nxt = '0;
                end else if (w_at_limit) begin
                    w_state_nxt = S_RETRY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RETRY: begin
                w_retry_nxt = w_retry_inc;
                w_cnt_nxt   = '0;
                if (w_retry_inc == RET_W'(MAX_RETRIES)) begin
                    w_state_nxt   = S_DONE;
                    w_pass_nxt    = 1'b0;
                    w_fail_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_RD_ID;
                end
            end
            S_CHECK: begin
                w_pass_nxt    = (r_id == EXP_ID) && (r_ts == EXP_TIMESTAMP);
                w_fail_nxt    = !((r_id == EXP_ID) && (r_ts == EXP_TIMESTAMP));
                w_timeout_nxt = 1'b0;
                w_state_nxt   = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    w_pass_nxt    = 1'b0;
                    w_fail_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_retry_nxt   = '0;
                    w_state_nxt   = S_RD_ID;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_read_nxt = (w_state_nxt == S_RD_ID) || (w_state_nxt == S_RD_TS);
        w_addr_nxt = (w_state_nxt == S_RD_TS);
        w_busy_nxt = (w_state_nxt == S_RD_ID) || (w_state_nxt == S_RD_TS) ||
                     (w_state_nxt == S_RETRY) || (w_state_nxt == S_CHECK);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_autorun <= 1'b1;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_id      <= '0;
            r_ts      <= '0;
            r_read    <= 1'b0;
            r_addr    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retry   <= w_retry_nxt;
            r_autorun <= w_autorun_nxt;
            r_pass    <= w_pass_nxt;
            r_fail    <= w_fail_nxt;
            r_timeout <= w_timeout_nxt;
            r_id      <= w_id_nxt;
            r_ts      <= w_ts_nxt;
            r_read    <= w_read_nxt;
            r_addr    <= w_addr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

`ifdef LIMBUS_SYSID_CHK_IRQ_EN
    logic r_irq, w_irq_set;

    // A new failure wins over a simultaneous clear.
    assign w_irq_set = (w_state_nxt == S_DONE) && (r_state != S_DONE) && w_fail_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

    assign avm_read    = r_read;
    assign avm_address = r_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign id_rd       = r_id;
    assign ts_rd       = r_ts;

endmodule

// File: tb/tb_limbus_sysid_checker.sv
// Self-checking bench for limbus_sysid_checker: randomized slave data/stalls against a latency/outcome model.
module tb_limbus_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd1;
    localparam logic [31:0] EXP_TS = 32'd1384067151;
    localparam int T = 4;
    localparam int M = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest = 1'b0;
    logic        busy, done, pass, fail, timeout;
    logic [31:0] id_rd, ts_rd;
`ifdef LIMBUS_SYSID_CHK_IRQ_EN
    logic        irq;
    logic        irq_clr = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] slave_id = EXP_ID, slave_ts = EXP_TS;
    int stall_n = 0, stall_left = 0;
    bit stuck_mode = 0;

    int n_rd_cyc = 0, n_bursts = 0, n_acc_id = 0, n_acc_ts = 0, n_glitch = 0;
    logic prev_read = 0, prev_wait = 0, prev_addr = 0;

    logic [31:0] m_id = 0, m_ts = 0;

    limbus_sysid_checker #(
        .EXP_ID(EXP_ID), .EXP_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES(T), .MAX_RETRIES(M), .CNT_W(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
`ifdef LIMBUS_SYSID_CHK_IRQ_EN
        .irq(irq), .irq_clr(irq_clr),
`endif
        .id_rd(id_rd), .ts_rd(ts_rd)
    );

    always #5 clock = ~clock;

    assign avm_readdata = avm_address ? slave_ts : slave_id;

    // Slave: stall each transfer stall_n cycles, or stall forever when stuck.
    always @(negedge clock) begin
        if (avm_read) begin
            if (stuck_mode) avm_waitrequest = 1'b1;
            else if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm_waitrequest = 1'b0;
                stall_left = stall_n;
            end
        end else begin
            avm_waitrequest = stuck_mode;
        end
    end

    // Bus monitor: read cycles, bursts, accepted transfers, address/strobe misbehaviour.
    always @(posedge clock) begin
        if (avm_read) n_rd_cyc++;
        if (avm_read && !prev_read) n_bursts++;
        if (avm_read && !avm_waitrequest) begin
            if (avm_address) n_acc_ts++;
            else n_acc_id++;
        end
        if (!avm_read && avm_address) n_glitch++;
        if (prev_read && prev_wait && avm_read && (avm_address != prev_addr)) n_glitch++;
        if (prev_read && prev_wait && !avm_read && !stuck_mode) n_glitch++;
        prev_read = avm_read;
        prev_wait = avm_waitrequest;
        prev_addr = avm_address;
    end

    task automatic run_check(input string name, input bit kick, input logic [31:0] sid,
                             input logic [31:0] sts, input int stall, input bit stuck,
                             input bit mid_start);
        int  exp_edge, exp_rd, exp_burst, exp_aid, exp_ats, n;
        bit  exp_pass, got_done, busy_ok;
        slave_id = sid;
        slave_ts = sts;
        if (stuck) begin
            exp_edge  = 1 + M * (T + 1);
            exp_rd    = M * T;
            exp_burst = M;
            exp_aid   = 0;
            exp_ats   = 0;
            exp_pass  = 0;
        end else begin
            exp_edge  = 4 + 2 * stall;
            exp_rd    = 2 * (stall + 1);
            exp_burst = 1;
            exp_aid   = 1;
            exp_ats   = 1;
            m_id      = sid;
            m_ts      = sts;
            exp_pass  = (sid == EXP_ID) && (sts == EXP_TS);
        end
        @(negedge clock);
        stall_n = stall;
        stall_left = stall;
        stuck_mode = stuck;
        n_rd_cyc = 0; n_bursts = 0; n_acc_id = 0; n_acc_ts = 0; n_glitch = 0;
        if (kick) start = 1'b1;
        else reset_n = 1'b1;
        n = 0;
        got_done = 0;
        busy_ok = 1;
        while (!got_done && n < exp_edge + 20) begin
            @(negedge clock);
            n++;
            start = (mid_start && n == 2) ? 1'b1 : 1'b0;
            if (done) got_done = 1;
            else if (!busy) busy_ok = 0;
        end
        start = 1'b0;
        n_tests++;
        if (!got_done || n != exp_edge) begin
            n_fail++;
            $display("FAIL %s done_edge: got %0d (done=%0b) want %0d", name, n, got_done, exp_edge);
        end
        n_tests++;
        if ({pass, fail, timeout} !== {exp_pass, !exp_pass, stuck}) begin
            n_fail++;
            $display("FAIL %s status: got pass/fail/timeout=%b want %b", name,
                     {pass, fail, timeout}, {exp_pass, !exp_pass, stuck});
        end
        n_tests++;
        if (id_rd !== m_id || ts_rd !== m_ts) begin
            n_fail++;
            $display("FAIL %s captured: got id=%h ts=%h want id=%h ts=%h", name, id_rd, ts_rd, m_id, m_ts);
        end
        n_tests++;
        if (n_acc_id != exp_aid || n_acc_ts != exp_ats || n_rd_cyc != exp_rd || n_bursts != exp_burst) begin
            n_fail++;
            $display("FAIL %s bus: got acc_id=%0d acc_ts=%0d rd_cyc=%0d bursts=%0d want %0d %0d %0d %0d",
                     name, n_acc_id, n_acc_ts, n_rd_cyc, n_bursts, exp_aid, exp_ats, exp_rd, exp_burst);
        end
        n_tests++;
        if (n_glitch != 0 || !busy_ok) begin
            n_fail++;
            $display("FAIL %s strobe: got glitches=%0d busy_ok=%0b want 0 1", name, n_glitch, busy_ok);
        end
        repeat (2) @(negedge clock);
        n_tests++;
        if ({done, busy, pass, fail} !== {1'b1, 1'b0, exp_pass, !exp_pass}) begin
            n_fail++;
            $display("FAIL %s hold: got done/busy/pass/fail=%b want %b", name,
                     {done, busy, pass, fail}, {1'b1, 1'b0, exp_pass, !exp_pass});
        end
    endtask

    task automatic check_zero(input string name);
        logic [70:0] obs;
        obs = {avm_read, avm_address, busy, done, pass, fail, timeout, id_rd, ts_rd};
        n_tests++;
        if (obs !== 71'b0) begin
            n_fail++;
            $display("FAIL %s outputs: got %h want 0", name, obs);
        end
`ifdef LIMBUS_SYSID_CHK_IRQ_EN
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s irq: got %b want 0", name, irq);
        end
`endif
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        check_zero("reset");
        run_check("auto_pass", 0, EXP_ID, EXP_TS, 0, 0, 0);
    endtask

    task automatic test_bad_id();
        run_check("bad_id", 1, 32'h2, EXP_TS, 0, 0, 0);
    endtask

    task automatic test_stall();
        run_check("stall3", 1, EXP_ID, EXP_TS, 3, 0, 0);
    endtask

    task automatic test_timeout();
        run_check("timeout", 1, EXP_ID, EXP_TS, 0, 1, 0);
`ifdef LIMBUS_SYSID_CHK_IRQ_EN
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set: got %b want 1", irq);
        end
        @(negedge clock);
        irq_clr = 1'b1;
        @(negedge clock);
        irq_clr = 1'b0;
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clr: got %b want 0", irq);
        end
`endif
    endtask

    task automatic test_restart_mid_start();
        run_check("pre_pass", 1, EXP_ID, EXP_TS, 0, 0, 0);
        run_check("bad_ts_midstart", 1, EXP_ID, EXP_TS ^ 32'h0000_0100, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] sid, sts;
            int kind, stall;
            bit stuck;
            kind  = int'($urandom_range(0, 2));
            stall = int'($urandom_range(0, T - 1));
            stuck = ($urandom_range(0, 5) == 0);
            sid   = (kind == 1) ? (EXP_ID ^ (32'($urandom) | 32'h1)) : EXP_ID;
            sts   = (kind == 2) ? (EXP_TS ^ (32'($urandom) | 32'h8)) : EXP_TS;
            run_check($sformatf("rand%0d", i), 1, sid, sts, stall, stuck, bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        slave_id = EXP_ID;
        slave_ts = EXP_TS;
        stall_n = 3;
        stall_left = 3;
        stuck_mode = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_zero("reset_mid_rd_ts");
        m_id = 0;
        m_ts = 0;
        repeat (2) @(negedge clock);
        run_check("post_reset_pass", 0, EXP_ID, EXP_TS, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_bad_id();
        test_stall();
        test_timeout();
        test_restart_mid_start();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
